// File: rtl/aib_avmm_csr_arb.sv
// Two-master round-robin arbiter onto one AVMM CSR slave, one read outstanding.
// Optional read-response timeout: define AIB_AVMM_ARB_TIMEOUT_EN.
module aib_avmm_csr_arb #(
    parameter int AW          = 7,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   m0_address,
    input  logic            m0_write,
    input  logic            m0_read,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,
    input  logic [AW-1:0]   m1_address,
    input  logic            m1_write,
    input  logic            m1_read,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,
    output logic [AW-1:0]   s_address,
    output logic            s_write,
    output logic            s_read,
    output logic [DW-1:0]   s_writedata,
    output logic [DW/8-1:0] s_byteenable,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_readdatavalid,
    output logic            rd_err
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

    logic [0:0]      r_state;
    logic            r_rr_last;
    logic            r_owner;
    logic [AW-1:0]   r_s_addr;
    logic            r_s_write;
    logic            r_s_read;
    logic [DW-1:0]   r_s_wdata;
    logic [DW/8-1:0] r_s_be;
    logic [DW-1:0]   r_m0_rdata;
    logic [DW-1:0]   r_m1_rdata;
    logic            r_m0_rvalid;
    logic            r_m1_rvalid;

    logic            w_req0;
    logic            w_req1;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_gnt;
    logic            w_in_rd;
    logic            w_wr;
    logic            w_rd;
    logic            w_tmo;
    logic            w_done;
    logic [DW-1:0]   w_rdata;

    assign w_req0  = m0_read | m0_write;
    assign w_req1  = m1_read | m1_write;
    assign w_in_rd = (r_state == ST_RD_WAIT);

    // rr_last names the previous winner; the other master wins a tie
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!w_in_rd) begin
            unique case ({w_req1, w_req0})
                2'b01:   w_gnt0 = 1'b1;
                2'b10:   w_gnt1 = 1'b1;
                2'b11: begin
                    w_gnt0 = r_rr_last;
                    w_gnt1 = ~r_rr_last;
                end
                default: ;
            endcase
        end
    end

    assign w_gnt = w_gnt0 | w_gnt1;
    assign w_wr  = w_gnt1 ? m1_write : m0_write;
    assign w_rd  = (w_gnt1 ? m1_read : m0_read) & ~w_wr;

    assign m0_waitrequest = ~reset_n | (w_req0 & ~w_gnt0);
    assign m1_waitrequest = ~reset_n | (w_req1 & ~w_gnt1);

`ifdef AIB_AVMM_ARB_TIMEOUT_EN
    logic [7:0] r_tcnt;
    logic       r_rd_err;

    // A real response in the timeout cycle takes priority
    assign w_tmo = w_in_rd & ~s_readdatavalid &
                   (r_tcnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt   <= '0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_gnt && w_rd) begin
                r_tcnt <= '0;
            end else if (w_in_rd) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
            if (w_tmo) begin
                r_rd_err <= 1'b1;
            end
        end
    end

    assign rd_err = r_rd_err;
`else
    assign w_tmo  = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign w_done  = w_in_rd & (s_readdatavalid | w_tmo);
    assign w_rdata = s_readdatavalid ? s_readdata : DW'(32'hDEADBEEF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rr_last   <= 1'b1;
            r_owner     <= 1'b0;
            r_s_addr    <= '0;
            r_s_write   <= 1'b0;
            r_s_read    <= 1'b0;
            r_s_wdata   <= '0;
            r_s_be      <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_s_write   <= w_gnt & w_wr;
            r_s_read    <= w_gnt & w_rd;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            if (w_gnt) begin
                r_rr_last <= w_gnt1;
                r_s_addr  <= w_gnt1 ? m1_address : m0_address;
                r_s_wdata <= w_gnt1 ? m1_writedata : m0_writedata;
                r_s_be    <= w_gnt1 ? m1_byteenable : m0_byteenable;
                if (w_rd) begin
                    r_owner <= w_gnt1;
                    r_state <= ST_RD_WAIT;
                end
            end
            if (w_done) begin
                r_state <= ST_IDLE;
                if (r_owner) begin
                    r_m1_rdata  <= w_rdata;
                    r_m1_rvalid <= 1'b1;
                end else begin
                    r_m0_rdata  <= w_rdata;
                    r_m0_rvalid <= 1'b1;
                end
            end
        end
    end

    assign s_address        = r_s_addr;
    assign s_write          = r_s_write;
    assign s_read           = r_s_read;
    assign s_writedata      = r_s_wdata;
    assign s_byteenable     = r_s_be;
    assign m0_readdata      = r_m0_rdata;
    assign m1_readdata      = r_m1_rdata;
    assign m0_readdatavalid = r_m0_rvalid;
    assign m1_readdatavalid = r_m1_rvalid;

endmodule

// File: tb/tb_aib_avmm_csr_arb.sv
// Directed bench for aib_avmm_csr_arb: per-cycle vector table plus
// reset-mid-read and (with AIB_AVMM_ARB_TIMEOUT_EN) timeout sequences.
module tb_aib_avmm_csr_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  m0_address, m1_address, s_address;
    logic        m0_write, m0_read, m1_write, m1_read;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_write, s_read, s_readdatavalid, rd_err;

    always #5 clk = ~clk;

    aib_avmm_csr_arb #(.AW(7), .DW(32), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_write(m0_write),
        .m0_read(m0_read), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_write(m1_write),
        .m1_read(m1_read), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_write(s_write), .s_read(s_read),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .rd_err(rd_err)
    );

    typedef struct packed {
        logic        m0w, m0r;
        logic [6:0]  m0a;
        logic [31:0] m0d;
        logic        m1w, m1r;
        logic [6:0]  m1a;
        logic [31:0] m1d;
        logic        srv;
        logic [31:0] sdat;
        logic        ew0, ew1, esw, esr;
        logic [6:0]  ea;
        logic [31:0] ed;
        logic [3:0]  eb;
        logic        ev0, ev1;
        logic [31:0] erd;
    } vec_t;

    vec_t        vq[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] e_rd0 = '0;
    logic [31:0] e_rd1 = '0;

    function automatic vec_t mk(
        input logic m0w, m0r, input logic [6:0] m0a,
        input logic [31:0] m0d,
        input logic m1w, m1r, input logic [6:0] m1a,
        input logic [31:0] m1d,
        input logic srv, input logic [31:0] sdat,
        input logic ew0, ew1, esw, esr,
        input logic [6:0] ea, input logic [31:0] ed,
        input logic [3:0] eb, input logic ev0, ev1,
        input logic [31:0] erd);
        vec_t t;
        t.m0w = m0w; t.m0r = m0r; t.m0a = m0a; t.m0d = m0d;
        t.m1w = m1w; t.m1r = m1r; t.m1a = m1a; t.m1d = m1d;
        t.srv = srv; t.sdat = sdat;
        t.ew0 = ew0; t.ew1 = ew1; t.esw = esw; t.esr = esr;
        t.ea = ea; t.ed = ed; t.eb = eb;
        t.ev0 = ev0; t.ev1 = ev1; t.erd = erd;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic drive(input vec_t t);
        m0_write = t.m0w; m0_read = t.m0r;
        m0_address = t.m0a; m0_writedata = t.m0d;
        m1_write = t.m1w; m1_read = t.m1r;
        m1_address = t.m1a; m1_writedata = t.m1d;
        s_readdatavalid = t.srv; s_readdata = t.sdat;
    endtask

    task automatic idle_in();
        m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
        s_readdatavalid = 0;
    endtask

    initial begin
        reset_n = 0;
        m0_address = '0; m1_address = '0;
        m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'h3;
        s_readdata = '0;
        idle_in();

        // Columns: m0 w r a d | m1 w r a d | srv sdat |
        //          wait0 wait1 s_write s_read addr wdata be | v0 v1 rdata
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,7'h24,32'hA0A0_0000, 1,0,7'h28,32'hB0B0_0000,
                        0,0, 0,1,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,7'h24,32'hA0A0_0000, 1,0,7'h28,32'hB0B0_0000,
                        0,0, 1,0,1,0,7'h24,32'hA0A0_0000,4'hF, 0,0,0));
        vq.push_back(mk(1,0,7'h24,32'hA0A0_0000, 1,0,7'h28,32'hB0B0_0000,
                        0,0, 0,1,1,0,7'h28,32'hB0B0_0000,4'h3, 0,0,0));
        vq.push_back(mk(1,0,7'h24,32'hA0A0_0000, 1,0,7'h28,32'hB0B0_0000,
                        0,0, 1,0,1,0,7'h24,32'hA0A0_0000,4'hF, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,1,0,7'h28,32'hB0B0_0000,4'h3, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,7'h20,32'h1234_5678, 0,0,0,0, 0,0,
                        0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,1,0,7'h20,32'h1234_5678,4'hF, 0,0,0));
        // m1 read, 1-cycle slave
        vq.push_back(mk(0,0,0,0, 0,1,7'h1c,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,0,1,7'h1c,0,4'h3, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'hCAFE_0001,
                        0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,0,0,0,0,0, 0,1,32'hCAFE_0001));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));
        // read blocking: m0 write stalls until m1 data returns
        vq.push_back(mk(0,0,0,0, 0,1,7'h10,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,7'h34,32'hC0, 0,0,0,0, 0,0,
                        1,0,0,1,7'h10,0,4'h3, 0,0,0));
        vq.push_back(mk(1,0,7'h34,32'hC0, 0,0,0,0, 1,32'h5555_AAAA,
                        1,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(1,0,7'h34,32'hC0, 0,0,0,0, 0,0,
                        0,0,0,0,0,0,0, 0,1,32'h5555_AAAA));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,1,0,7'h34,32'hC0,4'hF, 0,0,0));
        // stray response in IDLE
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'hFFFF_FFFF,
                        0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));
        // write+read together is a write; FSM stays IDLE
        vq.push_back(mk(1,1,7'h3c,32'h77, 0,0,0,0, 0,0,
                        0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,0,0, 1,0,7'h38,32'h99, 0,0,
                        0,0,1,0,7'h3c,32'h77,4'hF, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,1,0,7'h38,32'h99,4'h3, 0,0,0));
        // m0 read routing
        vq.push_back(mk(0,1,7'h04,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,0,1,7'h04,0,4'hF, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h1111_2222,
                        0,0,0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,
                        0,0,0,0,0,0,0, 1,0,32'h1111_2222));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0, 0,0,0));

        @(negedge clk); #1;
        chk("rst_wait0", 32'(m0_waitrequest), 1);
        chk("rst_wait1", 32'(m1_waitrequest), 1);
        chk("rst_swr", 32'(s_write), 0);
        chk("rst_srd", 32'(s_read), 0);
        chk("rst_saddr", 32'(s_address), 0);
        chk("rst_swd", s_writedata, 0);
        chk("rst_v0", 32'(m0_readdatavalid), 0);
        chk("rst_v1", 32'(m1_readdatavalid), 0);
        chk("rst_err", 32'(rd_err), 0);
        reset_n = 1;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t t;
            t = vq[i];
            @(negedge clk);
            drive(t);
            #1;
            chk($sformatf("r%0d_wait0", i), 32'(m0_waitrequest), 32'(t.ew0));
            chk($sformatf("r%0d_wait1", i), 32'(m1_waitrequest), 32'(t.ew1));
            chk($sformatf("r%0d_swr", i), 32'(s_write), 32'(t.esw));
            chk($sformatf("r%0d_srd", i), 32'(s_read), 32'(t.esr));
            if (t.esw || t.esr) begin
                chk($sformatf("r%0d_saddr", i), 32'(s_address), 32'(t.ea));
                chk($sformatf("r%0d_sbe", i), 32'(s_byteenable), 32'(t.eb));
            end
            if (t.esw)
                chk($sformatf("r%0d_swd", i), s_writedata, t.ed);
            chk($sformatf("r%0d_v0", i), 32'(m0_readdatavalid), 32'(t.ev0));
            chk($sformatf("r%0d_v1", i), 32'(m1_readdatavalid), 32'(t.ev1));
            if (t.ev0) e_rd0 = t.erd;
            if (t.ev1) e_rd1 = t.erd;
            chk($sformatf("r%0d_rd0", i), m0_readdata, e_rd0);
            chk($sformatf("r%0d_rd1", i), m1_readdata, e_rd1);
            chk($sformatf("r%0d_err", i), 32'(rd_err), 0);
        end

        // reset while m1 read is outstanding
        @(negedge clk);
        idle_in(); m1_read = 1; m1_address = 7'h2c;
        #1 chk("mr_gnt1", 32'(m1_waitrequest), 0);
        @(negedge clk);
        m1_read = 0;
        #1 chk("mr_srd", 32'(s_read), 1);
        reset_n = 0; m0_write = 1; m1_write = 1;
        #1;
        chk("mr_rst_wait0", 32'(m0_waitrequest), 1);
        chk("mr_rst_wait1", 32'(m1_waitrequest), 1);
        chk("mr_rst_srd", 32'(s_read), 0);
        chk("mr_rst_saddr", 32'(s_address), 0);
        chk("mr_rst_sbe", 32'(s_byteenable), 0);
        e_rd0 = '0; e_rd1 = '0;
        chk("mr_rst_rd1", m1_readdata, e_rd1);
        @(negedge clk);
        reset_n = 1; m0_write = 0; m1_write = 0;
        s_readdatavalid = 1; s_readdata = 32'hABCD_1234;
        #1 chk("mr_v1_a", 32'(m1_readdatavalid), 0);
        @(negedge clk);
        s_readdatavalid = 0;
        #1;
        chk("mr_v0", 32'(m0_readdatavalid), 0);
        chk("mr_v1", 32'(m1_readdatavalid), 0);
        chk("mr_rd1", m1_readdata, e_rd1);
        m0_write = 1; m0_address = 7'h40; m0_writedata = 32'h1;
        m1_write = 1; m1_address = 7'h44; m1_writedata = 32'h2;
        #1;
        chk("mr_first_wait0", 32'(m0_waitrequest), 0);
        chk("mr_first_wait1", 32'(m1_waitrequest), 1);
        @(negedge clk);
        idle_in();
        #1;
        chk("mr_first_swr", 32'(s_write), 1);
        chk("mr_first_saddr", 32'(s_address), 32'h40);

`ifdef AIB_AVMM_ARB_TIMEOUT_EN
        // slave never answers m0 read
        @(negedge clk);
        m0_read = 1; m0_address = 7'h08;
        #1 chk("to_gnt0", 32'(m0_waitrequest), 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            m0_read = 0;
            m1_write = (k == 5);
            m1_address = 7'h48;
            #1;
            if (k == 5)
                chk("to_block1", 32'(m1_waitrequest), 1);
            if (k == 15) begin
                chk("to_v0_early", 32'(m0_readdatavalid), 0);
                chk("to_err_early", 32'(rd_err), 0);
            end
        end
        chk("to_v0", 32'(m0_readdatavalid), 1);
        chk("to_rd0", m0_readdata, 32'hDEAD_BEEF);
        chk("to_err", 32'(rd_err), 1);
        m1_write = 1;
        #1 chk("to_gnt1", 32'(m1_waitrequest), 0);
        @(negedge clk);
        idle_in();
        #1;
        chk("to_v0_off", 32'(m0_readdatavalid), 0);
        chk("to_err_sticky", 32'(rd_err), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
